// File: rtl/load_store_unit.sv
// Load/store initiator for the data port of dual_port_mem_controller: one request at a time,
// word-aligned transactions with byte enables. Define LSU_TIMEOUT_EN to build the handshake watchdog.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_is_store_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        resp_misaligned_out,
    output logic        resp_timeout_out,
    output logic [31:0] data_addr_out,
    output logic [31:0] data_wdata_out,
    output logic [3:0]  data_byte_en_out,
    output logic        data_read_en_out,
    output logic        data_write_en_out,
    output logic        data_valid_out,
    input  logic        data_ready_in,
    input  logic        data_rdata_valid_in,
    input  logic [31:0] data_rdata_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q;
    logic [31:0] addr_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        store_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        data_valid_q, read_en_q, write_en_q;
    logic [3:0]  byte_en_q;
    logic        resp_valid_q, resp_mis_q, resp_to_q;
    logic [31:0] resp_rdata_q;

    logic        accept_s, misaligned_s, timeout_s, store_n_s;
    logic [3:0]  be_s, be_n_s;
    logic [31:0] wdata_s, resp_rdata_d;
    logic        resp_mis_d, resp_to_d;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode the incoming request: lane enables, replicated write data, alignment.
    always_comb begin
        be_s         = 4'b1111;
        wdata_s      = req_wdata_in;
        misaligned_s = 1'b0;
        case (req_size_in)
            2'd0: begin
                be_s         = 4'b0001 << req_addr_in[1:0];
                wdata_s      = {4{req_wdata_in[7:0]}};
                misaligned_s = 1'b0;
            end
            2'd1: begin
                be_s         = 4'b0011 << req_addr_in[1:0];
                wdata_s      = {2{req_wdata_in[15:0]}};
                misaligned_s = req_addr_in[0];
            end
            default: begin
                be_s         = 4'b1111;
                wdata_s      = req_wdata_in;
                misaligned_s = (req_addr_in[1:0] != 2'b00);
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;

    // Watchdog: restarts on every accepted request, counts REQ and RDATA cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (state_q == S_REQ || state_q == S_RDATA) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign timeout_s = (state_q == S_REQ || state_q == S_RDATA) && (cnt_q == CNT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic and one-cycle response payload.
    always_comb begin
        state_d      = state_q;
        accept_s     = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        resp_mis_d   = 1'b0;
        resp_to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready_q && req_valid_in) begin
                    accept_s = 1'b1;
                    if (misaligned_s) begin
                        state_d    = S_RESP;
                        resp_mis_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (data_ready_in) begin
                    if (store_q) begin
                        state_d = S_RESP;
                    end else if (data_rdata_valid_in) begin
                        state_d      = S_RESP;
                        resp_rdata_d = load_extract(data_rdata_in, off_q, size_q, uns_q);
                    end else begin
                        state_d = S_RDATA;
                    end
                end else if (timeout_s) begin
                    state_d   = S_RESP;
                    resp_to_d = 1'b1;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RDATA: begin
                if (data_rdata_valid_in) begin
                    state_d      = S_RESP;
                    resp_rdata_d = load_extract(data_rdata_in, off_q, size_q, uns_q);
                end else if (timeout_s) begin
                    state_d   = S_RESP;
                    resp_to_d = 1'b1;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept_s) begin
            store_n_s = req_is_store_in;
            be_n_s    = be_s;
        end else begin
            store_n_s = store_q;
            be_n_s    = be_q;
        end
    end

    // State, request latch and registered port outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            addr_q       <= 32'h0000_0000;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            store_q      <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            be_q         <= 4'b0000;
            data_valid_q <= 1'b0;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            byte_en_q    <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_mis_q   <= 1'b0;
            resp_to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            if (accept_s) begin
                addr_q  <= {req_addr_in[31:2], 2'b00};
                off_q   <= req_addr_in[1:0];
                size_q  <= req_size_in;
                uns_q   <= req_unsigned_in;
                store_q <= req_is_store_in;
                wdata_q <= wdata_s;
                be_q    <= be_s;
            end
            data_valid_q <= (state_d == S_REQ);
            read_en_q    <= (state_d == S_REQ) && !store_n_s;
            write_en_q   <= (state_d == S_REQ) && store_n_s;
            byte_en_q    <= (state_d == S_REQ) ? be_n_s : 4'b0000;
            resp_valid_q <= (state_d == S_RESP);
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_to_q    <= resp_to_d;
        end
    end

    assign req_ready_out       = ready_q;
    assign resp_valid_out      = resp_valid_q;
    assign resp_rdata_out      = resp_rdata_q;
    assign resp_misaligned_out = resp_mis_q;
    assign resp_timeout_out    = resp_to_q;
    assign data_addr_out       = addr_q;
    assign data_wdata_out      = wdata_q;
    assign data_byte_en_out    = byte_en_q;
    assign data_read_en_out    = read_en_q;
    assign data_write_en_out   = write_en_q;
    assign data_valid_out      = data_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory model predicts transactions and responses,
// a memory responder answers the data port with random or fixed delays.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_in = 1'b0, req_ready_out, req_is_store_in = 1'b0, req_unsigned_in = 1'b0;
    logic [1:0]  req_size_in = 2'd0;
    logic [31:0] req_addr_in = 32'd0, req_wdata_in = 32'd0;
    logic        resp_valid_out, resp_misaligned_out, resp_timeout_out;
    logic [31:0] resp_rdata_out, data_addr_out, data_wdata_out;
    logic [3:0]  data_byte_en_out;
    logic        data_read_en_out, data_write_en_out, data_valid_out;
    logic        data_ready_in, data_rdata_valid_in;
    logic [31:0] data_rdata_in;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_is_store_in(req_is_store_in), .req_size_in(req_size_in),
        .req_unsigned_in(req_unsigned_in), .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
        .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out),
        .resp_misaligned_out(resp_misaligned_out), .resp_timeout_out(resp_timeout_out),
        .data_addr_out(data_addr_out), .data_wdata_out(data_wdata_out),
        .data_byte_en_out(data_byte_en_out), .data_read_en_out(data_read_en_out),
        .data_write_en_out(data_write_en_out), .data_valid_out(data_valid_out),
        .data_ready_in(data_ready_in), .data_rdata_valid_in(data_rdata_valid_in),
        .data_rdata_in(data_rdata_in)
    );

    typedef struct packed {logic [31:0] rdata; logic mis; logic to;} resp_t;
    typedef struct packed {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} txn_t;

    resp_t       exp_resp_q[$];
    txn_t        exp_txn_q[$];
    logic [7:0]  model_mem [0:63];
    logic [31:0] dut_mem [0:15];
    int          total = 0, bad = 0;
    int          cfg_ready_dly = 0, cfg_rdata_dly = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: memory as bytes, access of n bytes at address a.
    task automatic model_issue(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                               input logic [31:0] wd, input bit push_resp, input bit tmo);
        int n, lo, idx;
        logic [63:0] v;
        resp_t r;
        txn_t t;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lo = int'(a[1:0]);
        r = '0;
        t = '0;
        if (lo % n != 0) begin
            r.mis = 1'b1;
            if (push_resp) exp_resp_q.push_back(r);
            return;
        end
        if (tmo) begin
            r.to = 1'b1;
            exp_resp_q.push_back(r);
            return;
        end
        t.addr = a & 32'hFFFF_FFFC;
        t.we = st;
        for (int i = 0; i < n; i++) t.be[lo + i] = 1'b1;
        if (st) begin
            for (int j = 0; j < 4; j++) t.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
            for (int i = 0; i < n; i++) begin
                idx = (int'(a[5:0]) + i) % 64;
                model_mem[idx] = wd[8*i +: 8];
            end
        end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) begin
                idx = (int'(a[5:0]) + i) % 64;
                v = v | (64'(model_mem[idx]) << (8*i));
            end
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            r.rdata = v[31:0];
        end
        exp_txn_q.push_back(t);
        if (push_resp) exp_resp_q.push_back(r);
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input bit wait_resp, input bit tmo, output int lat);
        int g;
        g = 0;
        lat = -1;
        while (!req_ready_out && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("req_ready_wait", {31'd0, req_ready_out}, 32'd1);
        req_is_store_in = st; req_size_in = sz; req_unsigned_in = uns;
        req_addr_in = a; req_wdata_in = wd; req_valid_in = 1'b1;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        model_issue(st, sz, uns, a, wd, wait_resp, tmo);
        if (wait_resp) begin
            lat = 1;
            while (!resp_valid_out && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, data_addr_out, 32'd0);
        chk({tag, "_wdata"}, data_wdata_out, 32'd0);
        chk({tag, "_rdata"}, resp_rdata_out, 32'd0);
        chk({tag, "_ctl"}, {23'd0, req_ready_out, resp_valid_out, resp_misaligned_out, resp_timeout_out,
                           data_byte_en_out, data_read_en_out, data_write_en_out, data_valid_out}, 32'd0);
    endtask

    txn_t  mon_t;
    resp_t mon_r;

    // Monitor: compare every data-port handshake and every response against the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid_out && data_ready_in) begin
                if (exp_txn_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL txn_unexpected: got addr %h expected no transaction", data_addr_out);
                end else begin
                    mon_t = exp_txn_q.pop_front();
                    chk("txn_addr", data_addr_out, mon_t.addr);
                    chk("txn_be", {28'd0, data_byte_en_out}, {28'd0, mon_t.be});
                    chk("txn_rw", {30'd0, data_write_en_out, data_read_en_out}, {30'd0, mon_t.we, !mon_t.we});
                    if (mon_t.we) chk("txn_wdata", data_wdata_out, mon_t.wdata);
                end
            end
            if (resp_valid_out) begin
                if (exp_resp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_unexpected: got rdata %h expected no response", resp_rdata_out);
                end else begin
                    mon_r = exp_resp_q.pop_front();
                    chk("resp_rdata", resp_rdata_out, mon_r.rdata);
                    chk("resp_flags", {30'd0, resp_misaligned_out, resp_timeout_out}, {30'd0, mon_r.mis, mon_r.to});
                end
            end
        end
    end

    // Memory responder on the data port.
    int          rsp_rd, rsp_rv, rsp_k;
    logic        rsp_ld;
    logic [31:0] rsp_ad, rsp_wd;
    logic [3:0]  rsp_be;
    initial begin
        data_ready_in = 1'b0; data_rdata_valid_in = 1'b0; data_rdata_in = 32'd0;
        forever begin
            @(posedge clk); #1;
            data_rdata_in = $urandom;
            if (rst && data_valid_out) begin
                rsp_rd = (cfg_ready_dly < 0) ? int'($urandom_range(0, 3)) : cfg_ready_dly;
                rsp_k = 0;
                while (rsp_k < rsp_rd && data_valid_out) begin
                    @(posedge clk); #1;
                    rsp_k++;
                end
                if (data_valid_out) begin
                    rsp_ld = data_read_en_out; rsp_ad = data_addr_out;
                    rsp_be = data_byte_en_out; rsp_wd = data_wdata_out;
                    rsp_rv = (cfg_rdata_dly < 0) ? int'($urandom_range(0, 3)) : cfg_rdata_dly;
                    data_ready_in = 1'b1;
                    if (rsp_ld && rsp_rv == 0) begin
                        data_rdata_valid_in = 1'b1;
                        data_rdata_in = dut_mem[rsp_ad[5:2]];
                    end
                    @(posedge clk); #1;
                    data_ready_in = 1'b0; data_rdata_valid_in = 1'b0; data_rdata_in = $urandom;
                    if (!rsp_ld) begin
                        for (int j = 0; j < 4; j++)
                            if (rsp_be[j]) dut_mem[rsp_ad[5:2]][8*j +: 8] = rsp_wd[8*j +: 8];
                    end else if (rsp_rv > 0) begin
                        repeat (rsp_rv - 1) begin @(posedge clk); #1; end
                        data_rdata_valid_in = 1'b1;
                        data_rdata_in = dut_mem[rsp_ad[5:2]];
                        @(posedge clk); #1;
                        data_rdata_valid_in = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL sim_watchdog: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    int          lat, nresp;
    logic [31:0] v, ra;
    initial begin
        for (int w = 0; w < 16; w++) begin
            v = $urandom;
            dut_mem[w] = v;
            for (int b = 0; b < 4; b++) model_mem[4*w + b] = v[8*b +: 8];
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'd0, req_ready_out}, 32'd1);

        issue(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEADBEEF, 1'b1, 1'b0, lat);
        chk("store_word_lat", lat, 2);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5, 1'b1, 1'b0, lat);
        chk("store_byte_lat", lat, 2);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_8078, 1'b1, 1'b0, lat);
        issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, lat);
        chk("load_byte_lat", lat, 2);
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0, lat);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_1234, 1'b1, 1'b0, lat);
        cfg_rdata_dly = 3;
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, lat);
        chk("load_half_delayed_lat", lat, 5);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, lat);
        chk("load_half_u_delayed_lat", lat, 5);
        cfg_rdata_dly = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1, 1'b0, lat);
        chk("misaligned_lat", lat, 1);

`ifdef LSU_TIMEOUT_EN
        cfg_ready_dly = 40;
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, lat);
        chk("timeout_lat", lat, 17);
        cfg_ready_dly = 0;
        @(posedge clk); #1;
`endif

        // Reset while waiting for read data: no response, late data ignored.
        cfg_rdata_dly = 6;
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, lat);
        @(posedge clk); #1;
        chk("rdata_wait_no_valid", {31'd0, data_valid_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_midreset", {31'd0, req_ready_out}, 32'd1);
        nresp = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (resp_valid_out) nresp++;
        end
        chk("no_resp_after_midreset", nresp, 0);
        cfg_rdata_dly = -1;
        cfg_ready_dly = -1;

        repeat (300) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ra, $urandom, 1'b1, 1'b0, lat);
            chk("rand_resp_seen", {31'd0, resp_valid_out}, 32'd1);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("resp_queue_drained", exp_resp_q.size(), 0);
        chk("txn_queue_drained", exp_txn_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
